// File: rtl/im2_int_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : im2_int_ctrl_if
// Purpose  : CPU-side bus bundle between a Z80-style CPU and the IM2
//            interrupt controller.
// Signals  : bus_m1/bus_iorq/bus_mreq/bus_rd - CPU strobes, active-high
//            bus_d   [7:0]  - CPU data bus (read side, opcode snooping)
//            n_int          - INT request to the CPU, active-low
//            d_out   [7:0]  - vector driven to the CPU
//            d_oe           - d_out valid, selects d_out on the bus mux
// Modports : master = CPU side, slave = interrupt controller side
// Revision : 1.0 - initial release
// ============================================================================
interface im2_int_ctrl_if;
  logic       bus_m1;
  logic       bus_iorq;
  logic       bus_mreq;
  logic       bus_rd;
  logic [7:0] bus_d;
  logic       n_int;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (
    output bus_m1, bus_iorq, bus_mreq, bus_rd, bus_d,
    input  n_int, d_out, d_oe
  );

  modport slave (
    input  bus_m1, bus_iorq, bus_mreq, bus_rd, bus_d,
    output n_int, d_out, d_oe
  );
endinterface
`default_nettype wire

// File: rtl/im2_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : im2_int_ctrl
// Purpose  : Z80 interrupt-mode-2 controller. Latches per-source request
//            pulses, raises INT toward the CPU synchronised to the CPU clock,
//            supplies the IM2 vector during interrupt acknowledge and pulses
//            ack on the serviced source.
// Ports    : clk28      - sole clock, rising edge
//            rst_n      - synchronous active-low reset
//            clkcpu_ck  - one-clk28 pulse per CPU clock rising edge
//            irq        - per-source request pulses (index 0 = top priority)
//            irq_mask   - 1 = source enabled
//            vec_base   - vector base, bits [7:4] used
//            ack        - one-clk28 pulse on the acknowledged source
//            cpu        - CPU bus bundle (slave modport)
// Config   : IM2_RETI_TRACK_EN - when defined, adds the in-service register
//            and RETI (ED 4D) decoder so that only strictly higher-priority
//            sources may interrupt a running handler.
// Revision : 1.0 - initial release
// ============================================================================
module im2_int_ctrl #(
  parameter int NSRC = 4
) (
  input  wire logic            clk28,
  input  wire logic            rst_n,
  input  wire logic            clkcpu_ck,
  input  wire logic [NSRC-1:0] irq,
  input  wire logic [NSRC-1:0] irq_mask,
  input  wire logic [7:0]      vec_base,
  output logic      [NSRC-1:0] ack,
  im2_int_ctrl_if.slave        cpu
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] ack_q, ack_d;
  logic [2:0]      sel_q, sel_d;

  logic            intack_w;
  logic [NSRC-1:0] eligible_w;
  logic            cand_vld_w;
  logic [2:0]      cand_idx_w;

  assign intack_w = cpu.bus_m1 && cpu.bus_iorq;

`ifdef IM2_RETI_TRACK_EN
  logic [NSRC-1:0] in_service_q, in_service_d;
  logic            fetch_q;
  logic            ed_q, ed_d;
  logic            fetch_w;
  logic            fetch_fall_w;
  logic            reti_w;

  assign fetch_w      = cpu.bus_m1 && cpu.bus_mreq && cpu.bus_rd;
  // The opcode is taken on the edge where the fetch strobe drops.
  assign fetch_fall_w = fetch_q && !fetch_w;
  assign reti_w       = fetch_fall_w && ed_q && (cpu.bus_d == 8'h4D);

  // Any fetched opcode other than ED clears the prefix flag, so only an
  // ED immediately followed by 4D is recognised as RETI.
  always_comb begin
    ed_d = ed_q;
    if (fetch_fall_w) begin
      ed_d = (cpu.bus_d == 8'hED);
    end
  end

  // RETI retires the highest-priority handler; a new acknowledge marks its
  // source as in service.
  always_comb begin
    logic done;
    in_service_d = in_service_q;
    done         = 1'b0;
    if (reti_w) begin
      for (int i = 0; i < NSRC; i++) begin
        if (!done && in_service_q[i]) begin
          in_service_d[i] = 1'b0;
          done            = 1'b1;
        end
      end
    end
    in_service_d = in_service_d | ack_d;
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      in_service_q <= '0;
      fetch_q      <= 1'b0;
      ed_q         <= 1'b0;
    end else begin
      in_service_q <= in_service_d;
      fetch_q      <= fetch_w;
      ed_q         <= ed_d;
    end
  end

  // A source is blocked when it, or anything above it, is in service.
  always_comb begin
    logic blk;
    eligible_w = pending_q & irq_mask;
    blk        = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      blk = blk | in_service_q[i];
      if (blk) begin
        eligible_w[i] = 1'b0;
      end
    end
  end

  logic unused_w;
  assign unused_w = ^vec_base[3:0];
`else
  always_comb begin
    eligible_w = pending_q & irq_mask;
  end

  // Opcode snooping is only needed for RETI tracking.
  logic unused_w;
  assign unused_w = ^{cpu.bus_mreq, cpu.bus_rd, cpu.bus_d, vec_base[3:0]};
`endif

  // Fixed priority encoder: scanning downward leaves the lowest index.
  always_comb begin
    cand_vld_w = 1'b0;
    cand_idx_w = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible_w[i]) begin
        cand_vld_w = 1'b1;
        cand_idx_w = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (clkcpu_ck && cand_vld_w) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (intack_w) begin
          if (cand_vld_w) begin
            // Target is fixed only now, so a later higher-priority request
            // arriving during REQ still wins.
            state_d = ACK;
            sel_d   = cand_idx_w;
            for (int i = 0; i < NSRC; i++) begin
              if (cand_idx_w == 3'(i)) begin
                ack_d[i] = 1'b1;
              end
            end
          end else begin
            state_d = IDLE;
          end
        end else if (clkcpu_ck && !cand_vld_w) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (!intack_w) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new pulse on the acknowledged source in the same cycle re-arms it.
  assign pending_d = (pending_q & ~ack_d) | irq;

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ack_q     <= '0;
      sel_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      sel_q     <= sel_d;
    end
  end

  assign ack       = ack_q;
  assign cpu.n_int = (state_q != REQ);
  assign cpu.d_out = (state_q == ACK) ? {vec_base[7:4], sel_q, 1'b0} : 8'h00;
  assign cpu.d_oe  = (state_q == ACK) && intack_w;

endmodule
`default_nettype wire

// File: tb/tb_im2_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_im2_int_ctrl
// Purpose  : Self-checking bench for im2_int_ctrl. Expected vectors and ack
//            patterns are queued when requests are raised and compared when
//            the CPU side performs the interrupt acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im2_int_ctrl;
  localparam int NSRC = 4;

  typedef struct {
    logic [7:0]      vec;
    logic [NSRC-1:0] ackv;
  } exp_t;

  logic            clk28 = 1'b0;
  logic            rst_n = 1'b0;
  logic            clkcpu_ck = 1'b0;
  logic [NSRC-1:0] irq = '0;
  logic [NSRC-1:0] irq_mask = '1;
  logic [7:0]      vec_base = 8'hA0;
  logic [NSRC-1:0] ack;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cpu_cnt = 0;

  im2_int_ctrl_if bus ();

  im2_int_ctrl #(.NSRC(NSRC)) dut (
    .clk28     (clk28),
    .rst_n     (rst_n),
    .clkcpu_ck (clkcpu_ck),
    .irq       (irq),
    .irq_mask  (irq_mask),
    .vec_base  (vec_base),
    .ack       (ack),
    .cpu       (bus.slave)
  );

  always #5 clk28 = ~clk28;

  // CPU clock: one clk28-wide strobe every fourth clk28 cycle.
  initial begin
    forever begin
      @(negedge clk28);
      cpu_cnt++;
      clkcpu_ck = (cpu_cnt % 4 == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk28);
  endtask

  task automatic pulse_irq(input logic [NSRC-1:0] m);
    irq = m;
    tick();
    irq = '0;
  endtask

  task automatic push_exp(input logic [7:0] v, input logic [NSRC-1:0] a);
    exp_t e;
    e.vec  = v;
    e.ackv = a;
    sb.push_back(e);
  endtask

  task automatic wait_int(input int max, input string tag);
    int n = 0;
    while (bus.n_int !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    check_val(tag, 32'(bus.n_int), 32'd0);
  endtask

  task automatic quiet(input int n, input string tag);
    logic ok = 1'b1;
    repeat (n) begin
      tick();
      if (bus.n_int !== 1'b1 || ack !== '0) ok = 1'b0;
    end
    check_val(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_intack(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    bus.bus_m1   = 1'b1;
    bus.bus_iorq = 1'b1;
    tick();
    check_val({tag, "_d_oe"},  32'(bus.d_oe),  32'd1);
    check_val({tag, "_d_out"}, 32'(bus.d_out), 32'(e.vec));
    check_val({tag, "_ack"},   32'(ack),       32'(e.ackv));
    check_val({tag, "_n_int"}, 32'(bus.n_int), 32'd1);
    tick();
    check_val({tag, "_ack_once"}, 32'(ack), 32'd0);
    bus.bus_m1   = 1'b0;
    bus.bus_iorq = 1'b0;
    tick();
    check_val({tag, "_d_oe_off"}, 32'(bus.d_oe), 32'd0);
  endtask

  task automatic fetch(input logic [7:0] op);
    bus.bus_d    = op;
    bus.bus_m1   = 1'b1;
    bus.bus_mreq = 1'b1;
    bus.bus_rd   = 1'b1;
    tick();
    tick();
    bus.bus_m1   = 1'b0;
    bus.bus_mreq = 1'b0;
    bus.bus_rd   = 1'b0;
    tick();
    bus.bus_d = 8'h00;
    tick();
  endtask

  task automatic reti();
    fetch(8'hED);
    fetch(8'h4D);
  endtask

  initial begin
    bus.bus_m1   = 1'b0;
    bus.bus_iorq = 1'b0;
    bus.bus_mreq = 1'b0;
    bus.bus_rd   = 1'b0;
    bus.bus_d    = 8'h00;

    // Reset state
    repeat (3) tick();
    check_val("rst_n_int", 32'(bus.n_int), 32'd1);
    check_val("rst_d_oe",  32'(bus.d_oe),  32'd0);
    check_val("rst_d_out", 32'(bus.d_out), 32'h00);
    check_val("rst_ack",   32'(ack),       32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single request on source 2
    push_exp(8'hA4, 4'b0100);
    pulse_irq(4'b0100);
    wait_int(6, "single_int");
    do_intack("single");

    // Nesting: source 0 over in-service source 2, source 3 must wait
    push_exp(8'hA0, 4'b0001);
    pulse_irq(4'b0001);
    wait_int(6, "nest0_int");
    do_intack("nest0");
    push_exp(8'hA6, 4'b1000);
    pulse_irq(4'b1000);
`ifdef IM2_RETI_TRACK_EN
    quiet(12, "nest3_blocked_a");
    reti();
    quiet(12, "nest3_blocked_b");
    reti();
`endif
    wait_int(10, "nest3_int");
    do_intack("nest3");
`ifdef IM2_RETI_TRACK_EN
    reti();
`endif

    // Simultaneous sources 3 and 1
    push_exp(8'hA2, 4'b0010);
    push_exp(8'hA6, 4'b1000);
    pulse_irq(4'b1010);
    wait_int(6, "simul1_int");
    do_intack("simul1");
`ifdef IM2_RETI_TRACK_EN
    reti();
`endif
    wait_int(10, "simul3_int");
    do_intack("simul3");
`ifdef IM2_RETI_TRACK_EN
    reti();
`endif

    // Masked source stays silent, then requests once enabled
    irq_mask = 4'b1101;
    pulse_irq(4'b0010);
    quiet(12, "mask_quiet");
    push_exp(8'hA2, 4'b0010);
    irq_mask = 4'b1111;
    wait_int(5, "mask_int");
    do_intack("mask");
`ifdef IM2_RETI_TRACK_EN
    reti();

    // ED,00,4D is not RETI: source 3 stays blocked behind source 1
    vec_base = 8'h5F;
    push_exp(8'h52, 4'b0010);
    pulse_irq(4'b0010);
    wait_int(6, "reti_dec1_int");
    do_intack("reti_dec1");
    pulse_irq(4'b1000);
    fetch(8'hED);
    fetch(8'h00);
    fetch(8'h4D);
    quiet(12, "reti_dec_quiet");
    push_exp(8'h56, 4'b1000);
    reti();
    wait_int(10, "reti_dec3_int");
    do_intack("reti_dec3");
    reti();
    vec_base = 8'hA0;
`endif

    // Reset during REQ aborts the cycle and drops pending
    pulse_irq(4'b0100);
    wait_int(6, "rstreq_int");
    rst_n = 1'b0;
    tick();
    check_val("rstreq_n_int", 32'(bus.n_int), 32'd1);
    rst_n = 1'b1;
    quiet(12, "rstreq_quiet");
    bus.bus_m1   = 1'b1;
    bus.bus_iorq = 1'b1;
    tick();
    check_val("rstreq_d_oe",  32'(bus.d_oe),  32'd0);
    check_val("rstreq_ack",   32'(ack),       32'd0);
    check_val("rstreq_d_out", 32'(bus.d_out), 32'h00);
    bus.bus_m1   = 1'b0;
    bus.bus_iorq = 1'b0;
    repeat (2) tick();

    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
